alu_operand_sequencer: RTL
==========================

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 The module SHALL have parameter N_BITS, default 8, the operand and result width.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, asynchronous and active-high.
REQ-004 The module SHALL have port din, input, N_BITS, the byte stream carrying operand A, then operand B, then opcode (din[1:0]; din[N_BITS-1:2] ignored).
REQ-005 The module SHALL have ports din_valid (input, 1) and din_ready (output, 1), the input handshake; transfer when both are 1 at a rising edge.
REQ-006 The module SHALL have ports A (output, N_BITS, signed), B (output, N_BITS, signed) and F (output, 2), driving the ALU operands and opcode from registers.
REQ-007 The module SHALL have ports alu_result (input, N_BITS) and alu_flag (input, 1), the combinational ALU result and overflow flag.
REQ-008 The module SHALL have ports res_data (output, N_BITS) and res_flag (output, 1), the captured result and flag.
REQ-009 The module SHALL have ports res_valid (output, 1) and res_ready (input, 1), the output handshake.
REQ-010 The module SHALL have ports op_count (output, 8), completed transactions, wrapping; ovf_count (output, 8), flagged results, saturating; and busy (output, 1), high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, GET_B, GET_F, EXEC and HOLD.
REQ-012 din_ready SHALL be 1 in IDLE, GET_B and GET_F, and 0 in EXEC and HOLD.
REQ-013 IDLE SHALL load A on a din transfer and go to GET_B, otherwise hold.
REQ-014 GET_B SHALL load B on a transfer and go to GET_F, otherwise hold.
REQ-015 GET_F SHALL load F from din[1:0] on a transfer and go to EXEC, otherwise hold.
REQ-016 EXEC SHALL last exactly one cycle, with A, B and F stable, and at its closing edge capture alu_result into res_data and alu_flag into res_flag, then go to HOLD.
REQ-017 res_valid SHALL be 1 only in HOLD, asserting at the second rising edge after the F transfer (latency 2 cycles).
REQ-018 In HOLD, res_data, res_flag, A, B and F SHALL stay stable until res_ready=1 at a rising edge, then the FSM SHALL go to IDLE.
REQ-019 On each output handshake, op_count SHALL increment modulo 256 (255 -> 0).
REQ-020 On each output handshake with res_flag=1, ovf_count SHALL increment and saturate at 255.
REQ-021 din_valid outside the ready states SHALL have no effect; no byte is consumed or buffered.
REQ-022 A, B and F SHALL keep their last values in IDLE until overwritten by the next transaction.

Reset
REQ-023 reset=1 SHALL, asynchronously and in any state including mid-transaction, force the FSM to IDLE and clear A, B, F, res_data, res_flag, res_valid, op_count and ovf_count to 0, giving din_ready=1 and busy=0.
REQ-024 Partially loaded operands SHALL be discarded on reset; the first byte transferred after reset is operand A.

Structure
REQ-025 Package alu_seq_pkg SHALL hold N_BITS, the state enum and the opcode enum (OP_AND=00, OP_OR=01, OP_ADD=10, OP_SUB=11).
REQ-026 Sub-module event_counter (8-bit, with a parameter selecting wrap or saturate) SHALL implement op_count and ovf_count; the ALU is instantiated by the parent, not inside this block.

Verification (bench drives alu_result/alu_flag from a behavioural 8-bit ALU with correct signed overflow)
REQ-027 The bench SHALL cover: reset asserted mid-cycle -> all outputs 0, din_ready=1, busy=0 immediately, without waiting for a clock edge.
REQ-028 The bench SHALL cover: bytes 0x05, 0x03, 0x00 (AND) with res_ready=1 -> res_valid 2 cycles after the F transfer, res_data=0x01, res_flag=0, op_count=1.
REQ-029 The bench SHALL cover: bytes 100, 50, 0x02 (ADD) -> res_data=0x96, res_flag=1, ovf_count=1.
REQ-030 The bench SHALL cover: res_ready held 0 for 5 cycles with din_valid toggling -> res_valid, res_data and A/B/F stable, din_ready=0, nothing consumed; the next transaction starts cleanly after the handshake.
REQ-031 The bench SHALL cover: reset pulsed after A=0x7F is loaded -> state IDLE, A=0; next bytes 0x02, 0x01, 0x03 (SUB) give res_data=0x01.
REQ-032 The bench SHALL cover: 256 transactions of 127+1 (ADD) -> op_count wraps to 0 and ovf_count saturates at 255.

Source files
------------

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared width, FSM state and opcode definitions for the ALU operand sequencer.
package alu_seq_pkg;

  localparam int N_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_B = 3'd1,
    ST_GET_F = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } opcode_e;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Bundle of the sequencer's byte-stream, ALU and result signals, with a view for each side.
interface alu_seq_if #(
  parameter int N_BITS = alu_seq_pkg::N_BITS
);

  logic [N_BITS-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [N_BITS-1:0] A;
  logic [N_BITS-1:0] B;
  logic [1:0]        F;
  logic [N_BITS-1:0] alu_result;
  logic              alu_flag;
  logic [N_BITS-1:0] res_data;
  logic              res_flag;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        op_count;
  logic [7:0]        ovf_count;
  logic              busy;

  // Sequencer side: consumes bytes and ALU results, produces operands and results.
  modport master (
    input  din, din_valid, alu_result, alu_flag, res_ready,
    output din_ready, A, B, F, res_data, res_flag, res_valid,
           op_count, ovf_count, busy
  );

  // Environment side: byte source, ALU and result sink.
  modport slave (
    output din, din_valid, alu_result, alu_flag, res_ready,
    input  din_ready, A, B, F, res_data, res_flag, res_valid,
           op_count, ovf_count, busy
  );

endinterface

// File: rtl/alu_operand_sequencer_event_counter.sv
// 8-bit event counter; SATURATE selects sticking at 255 instead of wrapping to 0.
module event_counter #(
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(SATURATE && count_q == 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from a byte stream, presents them to an external ALU,
// captures its result and holds it until the consumer accepts it.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N_BITS = alu_seq_pkg::N_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BITS-1:0]        din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [N_BITS-1:0] A,
  output logic signed [N_BITS-1:0] B,
  output logic [1:0]               F,
  input  logic [N_BITS-1:0]        alu_result,
  input  logic                     alu_flag,
  output logic [N_BITS-1:0]        res_data,
  output logic                     res_flag,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               op_count,
  output logic [7:0]               ovf_count,
  output logic                     busy
);

  state_e                   state_q, state_d;
  logic signed [N_BITS-1:0] a_q, a_d;
  logic signed [N_BITS-1:0] b_q, b_d;
  opcode_e                  f_q, f_d;
  logic [N_BITS-1:0]        rdata_q, rdata_d;
  logic                     rflag_q, rflag_d;
  logic                     out_hs;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    f_d       = f_q;
    rdata_d   = rdata_q;
    rflag_d   = rflag_q;
    din_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        din_ready = 1'b1;
        busy      = 1'b0;
        if (din_valid) begin
          a_d     = din;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        din_ready = 1'b1;
        if (din_valid) begin
          b_d     = din;
          state_d = ST_GET_F;
        end
      end
      ST_GET_F: begin
        din_ready = 1'b1;
        if (din_valid) begin
          f_d     = opcode_e'(din[1:0]);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Operands have been stable for this whole cycle; sample the ALU now.
        rdata_d = alu_result;
        rflag_d = alu_flag;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the asynchronous reset clears all state, so a partially collected
  // transaction is dropped and the next byte is always operand A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= OP_AND;
      rdata_q <= '0;
      rflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      rdata_q <= rdata_d;
      rflag_q <= rflag_d;
    end
  end

  assign out_hs   = res_valid & res_ready;
  assign A        = a_q;
  assign B        = b_q;
  assign F        = f_q;
  assign res_data = rdata_q;
  assign res_flag = rflag_q;

  event_counter #(.SATURATE(1'b0)) u_op_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (out_hs),
    .count_o (op_count)
  );

  event_counter #(.SATURATE(1'b1)) u_ovf_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (out_hs & rflag_q),
    .count_o (ovf_count)
  );

endmodule
